// File: rtl/uart_rx_byte_if.sv
// Signal bundle between the serial line side and the byte consumer of uart_rx_byte.
interface uart_rx_byte_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  // master drives the serial line and consumes bytes; slave is the receiver
  modport master (output rx, input rx_data, rx_valid, frame_err, parity_err, busy);
  modport slave  (input rx, output rx_data, rx_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// UART receiver: 8N1 frames sampled at bit centre, byte strobe or framing-error strobe.
// Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err strobe.
module uart_rx_byte #(
  parameter int BPS_PARA = 1250
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_byte_if.slave bus
);
  localparam logic [12:0] CNT_LAST = 13'(BPS_PARA - 1);
  localparam logic [12:0] CNT_MID  = 13'((BPS_PARA >> 1) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        fall_edge;
  logic        bit_done;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser plus one history flop for edge detection; idle line is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign fall_edge = rx_prev_q & ~rx_sync_q;
  assign bit_done  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 13'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall_edge) state_d = START;
      end
      START: begin
        // A start bit that is high again at its centre was a glitch
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_bad_d = rx_sync_q ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Re-arm at the stop centre so a back-to-back start edge is not missed
        if (bit_done) begin
          cnt_d       = '0;
          state_d     = IDLE;
          frame_err_d = ~rx_sync_q;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          if (rx_sync_q && !par_bad_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
`else
          if (rx_sync_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_byte;
  localparam int BPS  = 16;
  localparam int HALF = BPS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Cycles from driving the start bit to seeing the strobe (one cycle of slack allowed)
  localparam int STROBE_LAT = 3 + HALF + (NBITS - 1) * BPS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_byte_if u_if();

  uart_rx_byte #(.BPS_PARA(BPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cycle;
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] data;
    logic       busy;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
    logic       exp_v;
    logic       exp_fe;
    logic       exp_pe;
    logic [7:0] exp_data;
  } vec_t;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endfunction

  // Strobe monitor: records every strobe cycle and checks exclusivity and single-cycle width
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    logic any;
    ev_t  e;
    any = u_if.rx_valid | u_if.frame_err | u_if.parity_err;
    if (any) begin
      e.cycle = cyc;
      e.v     = u_if.rx_valid;
      e.fe    = u_if.frame_err;
      e.pe    = u_if.parity_err;
      e.data  = u_if.rx_data;
      e.busy  = u_if.busy;
      evq.push_back(e);
      check("strobe_exclusive", {31'd0, u_if.rx_valid & (u_if.frame_err | u_if.parity_err)}, 0);
      check("strobe_width", {31'd0, prev_strobe}, 0);
`ifndef UART_RX_PARITY_EN
      check("parity_tied0", {31'd0, u_if.parity_err}, 0);
`endif
    end
    prev_strobe <= any;
  end

  task automatic send_bit(input logic b);
    u_if.rx = b;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            output int start);
    start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ flip);
`else
    if (flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop);
  endtask

  task automatic check_frame(input string name, input int start, input logic ev_v,
                             input logic ev_fe, input logic ev_pe, input logic [7:0] exp_data);
    ev_t e;
    int  lat;
    check({name, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({name, "_valid"}, {31'd0, e.v}, {31'd0, ev_v});
      check({name, "_frame_err"}, {31'd0, e.fe}, {31'd0, ev_fe});
      check({name, "_parity_err"}, {31'd0, e.pe}, {31'd0, ev_pe});
      check({name, "_busy_at_strobe"}, {31'd0, e.busy}, 0);
      lat = e.cycle - start;
      if (lat == STROBE_LAT + 1) lat = STROBE_LAT;
      check({name, "_latency"}, lat, STROBE_LAT);
    end
    evq.delete();
    check({name, "_data"}, {24'd0, u_if.rx_data}, {24'd0, exp_data});
    $display("frame %s data=%02h valid=%0b ferr=%0b perr=%0b", name, u_if.rx_data, ev_v, ev_fe, ev_pe);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vec_t       tbl[$];
    int         st;
    int         gap;
    logic       saw_busy;
    logic [7:0] model_data;
    logic [7:0] d;
    logic       stop, flip, ok;

    u_if.rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, u_if.rx_data}, 0);
    check("reset_rx_valid", {31'd0, u_if.rx_valid}, 0);
    check("reset_frame_err", {31'd0, u_if.frame_err}, 0);
    check("reset_parity_err", {31'd0, u_if.parity_err}, 0);
    check("reset_busy", {31'd0, u_if.busy}, 0);
    rst_n = 1'b1;

    repeat (200) @(negedge clk);
    check("idle_no_strobe", evq.size(), 0);
    check("idle_busy", {31'd0, u_if.busy}, 0);
    check("idle_rx_data", {24'd0, u_if.rx_data}, 0);

    // Good byte, then a framing error followed by a line stuck low
    send_frame(8'hA5, 1'b0, 1'b1, st);
    check_frame("a5_good", st, 1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0, st);
    check_frame("3c_ferr", st, 1'b0, 1'b1, 1'b0, 8'hA5);
    u_if.rx = 1'b0;
    repeat (100) @(negedge clk);
    check("held_low_no_strobe", evq.size(), 0);
    check("held_low_busy", {31'd0, u_if.busy}, 0);
    u_if.rx = 1'b1;
    repeat (2 * BPS) @(negedge clk);

    // Short low glitch is rejected at the start-bit centre
    u_if.rx = 1'b0;
    repeat (4) @(negedge clk);
    u_if.rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw_busy = saw_busy | u_if.busy;
    end
    check("glitch_busy_seen", {31'd0, saw_busy}, 1);
    check("glitch_busy_end", {31'd0, u_if.busy}, 0);
    check("glitch_no_strobe", evq.size(), 0);
    check("glitch_rx_data", {24'd0, u_if.rx_data}, 32'hA5);
    $display("glitch busy_seen=%0b busy_end=%0b", saw_busy, u_if.busy);

    // Directed table
    tbl.push_back('{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
    tbl.push_back('{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A});
    tbl.push_back('{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01});
    tbl.push_back('{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07});
    tbl.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07});
    tbl.push_back('{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07});
`endif
    foreach (tbl[k]) begin
      send_frame(tbl[k].data, tbl[k].flip, tbl[k].stop, st);
      check_frame($sformatf("vec%0d", k), st, tbl[k].exp_v, tbl[k].exp_fe, tbl[k].exp_pe,
                  tbl[k].exp_data);
      send_bit(1'b1);
    end

    // Back-to-back frames, then reset in the middle of a fourth
    send_frame(8'h00, 1'b0, 1'b1, st);
    check_frame("b2b_00", st, 1'b1, 1'b0, 1'b0, 8'h00);
    send_frame(8'hFF, 1'b0, 1'b1, st);
    check_frame("b2b_ff", st, 1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'h55, 1'b0, 1'b1, st);
    check_frame("b2b_55", st, 1'b1, 1'b0, 1'b0, 8'h55);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rx_data", {24'd0, u_if.rx_data}, 0);
    check("abort_busy", {31'd0, u_if.busy}, 0);
    check("abort_rx_valid", {31'd0, u_if.rx_valid}, 0);
    u_if.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * BPS) @(negedge clk);
    check("abort_no_strobe", evq.size(), 0);
    check("abort_rx_data_after", {24'd0, u_if.rx_data}, 0);
    $display("abort rx_data=%02h busy=%0b", u_if.rx_data, u_if.busy);

    // Randomized frames against the frame-level reference model
    model_data = 8'h00;
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`else
      flip = 1'b0;
`endif
      ok = stop && !flip;
      if (ok) model_data = d;
      send_frame(d, flip, stop, st);
      check_frame($sformatf("rand%0d", n), st, ok, !stop, flip, model_data);
      gap = stop ? $urandom_range(0, 20) : $urandom_range(2, 20);
      u_if.rx = 1'b1;
      repeat (gap) @(negedge clk);
    end

    repeat (2 * BPS) @(negedge clk);
    check("final_no_stray_strobe", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
